capture_sequencer: RTL and testbench



---
 rtl/logicap_pkg.sv | 11 +
 rtl/trig_stage_match.sv | 29 ++
 rtl/capture_sequencer.sv | 175 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/logicap_pkg.sv
// Shared types and constants for the logic analyser capture path.
package logicap_pkg;

   typedef enum logic [1:0] {StIdle, StWait, StPost, StDone} capseq_state_t;

   localparam logic TRIG_LEVEL = 1'b0;
   localparam logic TRIG_EDGE  = 1'b1;

   localparam int unsigned STAGES_DEFAULT = 8;

endpackage

// File: rtl/trig_stage_match.sv
// Combinational matcher for one trigger stage: AND over all masked bits of
// a level or rising-to-level edge condition.
module trig_stage_match
   import logicap_pkg::*;
#(
   parameter int unsigned size = 32
) (
   input  logic [size-1:0] mask,
   input  logic [size-1:0] trig_type,
   input  logic [size-1:0] level,
   input  logic [size-1:0] sample,
   input  logic [size-1:0] prev,
   output logic            match
);

   logic [size-1:0] bit_ok;

   always_comb begin
      bit_ok = '0;
      for (int i = 0; i < size; i++) begin
         bit_ok[i] = !mask[i] ||
                     ((sample[i] == level[i]) &&
                      ((trig_type[i] == TRIG_LEVEL) || (prev[i] != level[i])));
      end
   end

   assign match = &bit_ok;

endmodule

// File: rtl/capture_sequencer.sv
// Multi-stage trigger sequencer gating trigger + post-trigger samples to the FIFO.
// Optional sample-count timeout in WAIT when CAPSEQ_TIMEOUT_EN is defined.
module capture_sequencer
   import logicap_pkg::*;
#(
   parameter int unsigned size    = 32,
   parameter int unsigned stages  = STAGES_DEFAULT,
   parameter int unsigned saddr_w = 24
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      arm,
   input  logic                      abort,
   input  logic [$clog2(stages)-1:0] last_stage,
   input  logic [stages*size-1:0]    trig_mask,
   input  logic [stages*size-1:0]    trig_type,
   input  logic [stages*size-1:0]    trig_level,
   input  logic [saddr_w-1:0]        post_trigger_count,
   input  logic [size-1:0]           s_tdata,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   output logic [size-1:0]           m_tdata,
   output logic                      m_tvalid,
   output logic                      m_tlast,
   input  logic                      m_tready,
   output logic                      armed,
   output logic                      triggered,
   output logic                      done,
   output logic                      overrun,
`ifdef CAPSEQ_TIMEOUT_EN
   input  logic [saddr_w-1:0]        timeout,
   output logic                      timed_out,
`endif
   output logic [$clog2(stages)-1:0] stage
);

   localparam int unsigned sw = $clog2(stages);

   capseq_state_t state;

   logic [sw-1:0]           last_stage_q;
   logic [stages*size-1:0]  mask_q, type_q, level_q;
   logic [saddr_w-1:0]      post_q, cnt_q, cnt_inc;
`ifdef CAPSEQ_TIMEOUT_EN
   logic [saddr_w-1:0]      timeout_q;
`endif
   logic [size-1:0]         prev_q, prev_eff;
   logic                    prev_valid_q;
   logic [size-1:0]         sel_mask, sel_type, sel_level;
   logic                    accept, match, final_hit, fwd, trig_last, post_last;

   assign s_tready  = 1'b1;
   assign accept    = s_tvalid;
   assign sel_mask  = mask_q[stage*size +: size];
   assign sel_type  = type_q[stage*size +: size];
   assign sel_level = level_q[stage*size +: size];
   // Before any sample has been seen, pretend the previous one was the inverse level.
   assign prev_eff  = prev_valid_q ? prev_q : ~sel_level;
   assign cnt_inc   = cnt_q + saddr_w'(1);

   trig_stage_match #(
      .size(size)
   ) u_match (
      .mask     (sel_mask),
      .trig_type(sel_type),
      .level    (sel_level),
      .sample   (s_tdata),
      .prev     (prev_eff),
      .match    (match)
   );

   assign final_hit = (state == StWait) && accept && match && (stage >= last_stage_q) && !abort;
   assign trig_last = (post_q == '0);
   assign post_last = (cnt_inc == post_q);
   assign fwd       = accept && !abort && ((state == StPost) || final_hit);

   assign m_tvalid = fwd;
   assign m_tdata  = fwd ? s_tdata : '0;
   assign m_tlast  = fwd && ((state == StPost) ? post_last : trig_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= StIdle;
         stage        <= '0;
         armed        <= 1'b0;
         triggered    <= 1'b0;
         done         <= 1'b0;
         overrun      <= 1'b0;
         cnt_q        <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         last_stage_q <= '0;
         mask_q       <= '0;
         type_q       <= '0;
         level_q      <= '0;
         post_q       <= '0;
`ifdef CAPSEQ_TIMEOUT_EN
         timeout_q    <= '0;
         timed_out    <= 1'b0;
`endif
      end else begin
         if (accept) begin
            prev_q       <= s_tdata;
            prev_valid_q <= 1'b1;
         end
         if (fwd && !m_tready) overrun <= 1'b1;

         if (abort) begin
            state <= StIdle;
            armed <= 1'b0;
            done  <= 1'b0;
         end else begin
            unique case (state)
               StIdle, StDone: begin
                  if (arm) begin
                     last_stage_q <= last_stage;
                     mask_q       <= trig_mask;
                     type_q       <= trig_type;
                     level_q      <= trig_level;
                     post_q       <= post_trigger_count;
`ifdef CAPSEQ_TIMEOUT_EN
                     timeout_q    <= timeout;
                     timed_out    <= 1'b0;
`endif
                     triggered    <= 1'b0;
                     done         <= 1'b0;
                     overrun      <= 1'b0;
                     stage        <= '0;
                     cnt_q        <= '0;
                     armed        <= 1'b1;
                     state        <= StWait;
                  end
               end
               StWait: begin
                  if (final_hit) begin
                     triggered <= 1'b1;
                     cnt_q     <= '0;
                     if (trig_last) begin
                        state <= StDone;
                        armed <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state <= StPost;
                     end
                  end else if (accept) begin
                     if (match) stage <= stage + sw'(1);
`ifdef CAPSEQ_TIMEOUT_EN
                     if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
                        state     <= StDone;
                        armed     <= 1'b0;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                     end else begin
                        cnt_q <= cnt_inc;
                     end
`endif
                  end
               end
               StPost: begin
                  if (accept) begin
                     cnt_q <= cnt_inc;
                     if (post_last) begin
                        state <= StDone;
                        armed <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed self-checking bench for capture_sequencer; covers the timeout path
// only when CAPSEQ_TIMEOUT_EN is defined.
module tb_capture_sequencer;

   localparam int unsigned size    = 32;
   localparam int unsigned stages  = 8;
   localparam int unsigned saddr_w = 24;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     arm, abort;
   logic [2:0]               last_stage;
   logic [stages*size-1:0]   trig_mask, trig_type, trig_level;
   logic [saddr_w-1:0]       post_trigger_count;
   logic [size-1:0]          s_tdata, m_tdata;
   logic                     s_tvalid, s_tready, m_tvalid, m_tlast, m_tready;
   logic                     armed, triggered, done, overrun;
   logic [2:0]               stage;
`ifdef CAPSEQ_TIMEOUT_EN
   logic [saddr_w-1:0]       timeout;
   logic                     timed_out;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   capture_sequencer #(
      .size   (size),
      .stages (stages),
      .saddr_w(saddr_w)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .arm               (arm),
      .abort             (abort),
      .last_stage        (last_stage),
      .trig_mask         (trig_mask),
      .trig_type         (trig_type),
      .trig_level        (trig_level),
      .post_trigger_count(post_trigger_count),
      .s_tdata           (s_tdata),
      .s_tvalid          (s_tvalid),
      .s_tready          (s_tready),
      .m_tdata           (m_tdata),
      .m_tvalid          (m_tvalid),
      .m_tlast           (m_tlast),
      .m_tready          (m_tready),
      .armed             (armed),
      .triggered         (triggered),
      .done              (done),
      .overrun           (overrun),
`ifdef CAPSEQ_TIMEOUT_EN
      .timeout           (timeout),
      .timed_out         (timed_out),
`endif
      .stage             (stage)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic l, input logic [31:0] d);
      chk(tag, {30'd0, m_tvalid, m_tlast, m_tdata}, {30'd0, v, l, d});
   endtask

   // One cycle of stimulus, applied at the falling edge and settled 1 ns later.
   task automatic drive(input logic [31:0] d, input logic v, input logic r,
                        input logic a_arm, input logic a_abort);
      @(negedge clk);
      s_tdata  = d;
      s_tvalid = v;
      m_tready = r;
      arm      = a_arm;
      abort    = a_abort;
      #1;
   endtask

   task automatic smp(input logic [31:0] d);
      drive(d, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_arm();
      drive(32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic cfg_single(input logic [23:0] post);
      last_stage         = 3'd0;
      trig_mask          = '0;
      trig_type          = '0;
      trig_level         = '0;
      trig_mask[31:0]    = 32'h1;
      trig_level[31:0]   = 32'h1;
      post_trigger_count = post;
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; abort = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
      cfg_single(24'd3);
`ifdef CAPSEQ_TIMEOUT_EN
      timeout = '0;
`endif
      repeat (3) @(negedge clk);
      #1;
      chk("rst_status", {armed, triggered, done, overrun}, 4'b0000);
      chk("rst_stage", stage, 3'd0);
      chk_out("rst_out", 1'b0, 1'b0, 32'd0);
      chk("rst_tready", s_tready, 1'b1);
      @(negedge clk);
      reset = 1'b0;

      // Single stage level trigger, post 3
      do_arm();
      smp(32'd0); chk("t1_armed", armed, 1'b1); chk_out("t1_s0", 1'b0, 1'b0, 32'd0);
      smp(32'd0); chk_out("t1_s1", 1'b0, 1'b0, 32'd0);
      smp(32'd1); chk_out("t1_trig", 1'b1, 1'b0, 32'd1);
      smp(32'd2); chk_out("t1_p1", 1'b1, 1'b0, 32'd2); chk("t1_triggered", triggered, 1'b1);
      smp(32'd3); chk_out("t1_p2", 1'b1, 1'b0, 32'd3);
      smp(32'd4); chk_out("t1_p3", 1'b1, 1'b1, 32'd4); chk("t1_not_done", done, 1'b0);
      smp(32'd5); chk_out("t1_after", 1'b0, 1'b0, 32'd0);
      chk("t1_done", {armed, done}, 2'b01);

      // Two stages: bit0 rising edge, then bit1 level high; post 1
      smp(32'd0); chk_out("t2_done_drop", 1'b0, 1'b0, 32'd0);
      last_stage = 3'd1;
      trig_mask = '0; trig_type = '0; trig_level = '0;
      trig_mask[31:0] = 32'h1; trig_type[31:0] = 32'h1; trig_level[31:0] = 32'h1;
      trig_mask[63:32] = 32'h2; trig_level[63:32] = 32'h2;
      post_trigger_count = 24'd1;
      do_arm();
      smp(32'd1); chk("t2_stage0", stage, 3'd0); chk_out("t2_s1", 1'b0, 1'b0, 32'd0);
      smp(32'd2); chk("t2_stage1", stage, 3'd1); chk_out("t2_trig", 1'b1, 1'b0, 32'd2);
      smp(32'd3); chk_out("t2_last", 1'b1, 1'b1, 32'd3); chk("t2_triggered", triggered, 1'b1);
      smp(32'd0); chk("t2_done", done, 1'b1);

      // One stage per sample, post 0: both stages match 3
      last_stage = 3'd1;
      trig_mask = '0; trig_type = '0; trig_level = '0;
      trig_mask[31:0] = 32'h3; trig_level[31:0] = 32'h3;
      trig_mask[63:32] = 32'h3; trig_level[63:32] = 32'h3;
      post_trigger_count = 24'd0;
      do_arm();
      smp(32'd3); chk_out("t3_adv_only", 1'b0, 1'b0, 32'd0);
      smp(32'd3); chk("t3_stage", stage, 3'd1); chk_out("t3_trig_last", 1'b1, 1'b1, 32'd3);
      smp(32'd7); chk_out("t3_after", 1'b0, 1'b0, 32'd0);
      chk("t3_status", {armed, triggered, done}, 3'b011);

      // Overrun: m_tready low once during POST, post 5
      cfg_single(24'd5);
      do_arm();
      smp(32'd1); chk_out("t4_trig", 1'b1, 1'b0, 32'd1);
      smp(32'd2); chk_out("t4_p1", 1'b1, 1'b0, 32'd2); chk("t4_no_ovr", overrun, 1'b0);
      drive(32'd3, 1'b1, 1'b0, 1'b0, 1'b0); chk_out("t4_p2_lost", 1'b1, 1'b0, 32'd3);
      smp(32'd4); chk("t4_ovr", overrun, 1'b1); chk_out("t4_p3", 1'b1, 1'b0, 32'd4);
      smp(32'd5); chk_out("t4_p4", 1'b1, 1'b0, 32'd5);
      smp(32'd6); chk_out("t4_p5", 1'b1, 1'b1, 32'd6);
      drive(32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_done_ovr", {done, overrun}, 2'b11);

      // Abort during POST after 2 of 5, then a clean re-arm with post 1
      do_arm();
      smp(32'd1); chk("t5_ovr_clr", overrun, 1'b0); chk_out("t5_trig", 1'b1, 1'b0, 32'd1);
      smp(32'd2); chk_out("t5_p1", 1'b1, 1'b0, 32'd2);
      smp(32'd3); chk_out("t5_p2", 1'b1, 1'b0, 32'd3);
      drive(32'd4, 1'b1, 1'b1, 1'b0, 1'b1); chk_out("t5_abort", 1'b0, 1'b0, 32'd0);
      smp(32'd5); chk("t5_idle", {armed, done}, 2'b00); chk_out("t5_idle_out", 1'b0, 1'b0, 32'd0);
      post_trigger_count = 24'd1;
      do_arm();
      smp(32'd0); chk("t5_rearm", armed, 1'b1); chk_out("t5_r0", 1'b0, 1'b0, 32'd0);
      smp(32'd1); chk_out("t5_rtrig", 1'b1, 1'b0, 32'd1);
      smp(32'd8); chk_out("t5_rlast", 1'b1, 1'b1, 32'd8);
      drive(32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t5_rdone", {armed, triggered, done}, 3'b011);

`ifdef CAPSEQ_TIMEOUT_EN
      // Timeout 10 with a trigger that never matches
      cfg_single(24'd2);
      timeout = 24'd10;
      do_arm();
      for (int i = 0; i < 9; i++) smp(32'd0);
      chk("t6_pre", {done, timed_out}, 2'b00);
      smp(32'd0);
      drive(32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_timeout", {done, timed_out, triggered}, 3'b110);
      do_arm();
      drive(32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_arm_clr", timed_out, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
